// File: rtl/reg_file_pkg.sv
// Shared types and sizing for the register-file port arbiter.
package reg_file_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {INIT, RUN, HALT} regf_state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } regf_req_t;

endpackage

// File: rtl/reg_file_arbiter_if.sv
// Requester, debug and register-file port signals of reg_file_arbiter.
interface reg_file_arbiter_if;
  import reg_file_pkg::*;

  logic              busy;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic [DATA_W-1:0] core_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_halt;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] rf_reg_in;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_write_ctrl;
  logic [DATA_W-1:0] rf_data_out;

  modport slave (
    output busy, core_gnt, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output rf_reg_in, rf_data_in, rf_write_ctrl,
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, rf_data_out
  );

  modport master (
    input  busy, core_gnt, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  rf_reg_in, rf_data_in, rf_write_ctrl,
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, rf_data_out
  );

endinterface

// File: rtl/reg_init_sweeper.sv
// Address counter for the post-reset clearing sweep; done marks the last address.
module reg_init_sweeper
  import reg_file_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign addr = cnt_q;
  assign done = en && (cnt_q == ADDR_W'(NUM_REGS - 1));

endmodule

// File: rtl/reg_file_arbiter.sv
// Owns the single register-file port: init sweep, core/debug arbitration, debug halt.
// Debug port, HALT state and starvation limit exist only when REGF_DBG_EN is defined.
module reg_file_arbiter
  import reg_file_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               CLK,
  input logic               RESET,
  reg_file_arbiter_if.slave bus
);

  regf_state_t       state_q, state_d;
  regf_req_t         core_r;
  logic [ADDR_W-1:0] init_addr, last_addr_q;
  logic              init_en, init_done;
  logic              core_gnt, dbg_gnt;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic [3:0]        unused_starve_max;

  assign unused_starve_max = 4'(STARVE_MAX);

  assign core_r = '{req: bus.core_req, we: bus.core_we, addr: bus.core_addr,
                    wdata: bus.core_wdata};

  assign init_en = (state_q == INIT) && !RESET;

  reg_init_sweeper u_sweeper (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (init_en),
    .addr  (init_addr),
    .done  (init_done)
  );

`ifdef REGF_DBG_EN
  regf_req_t  dbg_r;
  logic [3:0] starve_q, starve_d;
  logic       starve_full;
  logic       dbg_rvalid_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  assign dbg_r = '{req: bus.dbg_req, we: bus.dbg_we, addr: bus.dbg_addr,
                   wdata: bus.dbg_wdata};
  assign starve_full = (starve_q == 4'(STARVE_MAX));
`else
  logic unused_dbg;
  assign unused_dbg = ^{bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata, bus.dbg_halt};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= INIT;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      last_addr_q <= rf_addr;
    end
  end

  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    case (state_q)
      INIT: begin
        if (init_done) state_d = RUN;
      end
      RUN: begin
`ifdef REGF_DBG_EN
        // Core has priority until debug has waited STARVE_MAX core grants.
        if (dbg_r.req && (!core_r.req || starve_full)) begin
          dbg_gnt = 1'b1;
        end else begin
          core_gnt = core_r.req;
        end
        if (bus.dbg_halt) state_d = HALT;
`else
        core_gnt = core_r.req;
`endif
      end
`ifdef REGF_DBG_EN
      HALT: begin
        dbg_gnt = dbg_r.req;
        if (!bus.dbg_halt) state_d = RUN;
      end
`endif
      default: state_d = INIT;
    endcase
    if (RESET) begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
    end
  end

  always_comb begin
    rf_addr  = last_addr_q;
    rf_wdata = '0;
    rf_we    = 1'b0;
    if (state_q == INIT) begin
      rf_addr = init_addr;
      rf_we   = 1'b1;
    end else if (core_gnt) begin
      rf_addr  = core_r.addr;
      rf_wdata = core_r.wdata;
      rf_we    = core_r.we;
`ifdef REGF_DBG_EN
    end else if (dbg_gnt) begin
      rf_addr  = dbg_r.addr;
      rf_wdata = dbg_r.wdata;
      rf_we    = dbg_r.we;
`endif
    end
    if (RESET) rf_we = 1'b0;
  end

`ifdef REGF_DBG_EN
  always_comb begin
    starve_d = starve_q;
    if (state_q == INIT || dbg_gnt || !dbg_r.req) begin
      starve_d = '0;
    end else if (core_gnt && !starve_full) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_q     <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      dbg_rvalid_q <= dbg_gnt && !dbg_r.we;
      if (dbg_gnt && !dbg_r.we) dbg_rdata_q <= bus.rf_data_out;
    end
  end

  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
`else
  assign bus.dbg_gnt    = 1'b0;
  assign bus.dbg_rvalid = 1'b0;
  assign bus.dbg_rdata  = '0;
`endif

  assign bus.busy          = (state_q == INIT) || RESET;
  assign bus.core_gnt      = core_gnt;
  assign bus.core_rdata    = bus.rf_data_out;
  assign bus.rf_reg_in     = rf_addr;
  assign bus.rf_data_in    = rf_wdata;
  assign bus.rf_write_ctrl = rf_we;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter with a behavioural register file and reference model.
module tb_reg_file_arbiter;
  import reg_file_pkg::*;

  localparam int unsigned STARVE = 4;

  logic CLK = 1'b0;
  logic RESET;
  int   tests_run = 0;
  int   tests_failed = 0;

  reg_file_arbiter_if bus ();

  reg_file_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Register file instance the arbiter drives.
  logic [7:0] rf_mem [16];
  always @(posedge CLK) if (bus.rf_write_ctrl) rf_mem[bus.rf_reg_in] <= bus.rf_data_in;
  assign bus.rf_data_out = rf_mem[bus.rf_reg_in];

  // Reference contents and last driven address.
  logic [7:0] model [16];
  logic [3:0] exp_last;
  logic [7:0] exp_dbg_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [3:0] a,
                            input logic [7:0] d);
    bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [3:0] a,
                           input logic halt);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = 8'h00;
    bus.dbg_halt = halt;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk({tag, "_we"}, 32'(bus.rf_write_ctrl), 32'd1);
      chk({tag, "_addr"}, 32'(bus.rf_reg_in), 32'(i));
      chk({tag, "_data"}, 32'(bus.rf_data_in), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_cgnt"}, 32'(bus.core_gnt), 32'd0);
      tick();
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    exp_last = 4'd15;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
  end

  initial begin
    logic       c_req, c_we, d_req, d_halt, exp_d, prev_d;
    logic [3:0] c_addr;
    logic [7:0] c_wd;

    for (int i = 0; i < 16; i++) rf_mem[i] = 8'hEE;
    exp_dbg_rdata = 8'h00;
    RESET = 1'b1;
    core_drive(1'b1, 1'b1, 4'd2, 8'h11);
    dbg_drive(1'b0, 1'b0, 4'd0, 1'b0);
    tick();

    // Reset state.
    @(negedge CLK);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_cgnt", 32'(bus.core_gnt), 32'd0);
    chk("rst_dgnt", 32'(bus.dbg_gnt), 32'd0);
    chk("rst_we", 32'(bus.rf_write_ctrl), 32'd0);
    chk("rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("rst_rdata", 32'(bus.dbg_rdata), 32'd0);
    tick();

    // Init sweep with the core already requesting a read of addr 5.
    RESET = 1'b0;
    core_drive(1'b1, 1'b0, 4'd5, 8'h00);
    sweep_check("sweep");
    @(negedge CLK);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_cgnt", 32'(bus.core_gnt), 32'd1);
    chk("post_rd5", 32'(bus.core_rdata), 32'(model[5]));
    exp_last = 4'd5;
    tick();

    // Core write then read-back.
    core_drive(1'b1, 1'b1, 4'd3, 8'hA5);
    @(negedge CLK);
    chk("wr3_gnt", 32'(bus.core_gnt), 32'd1);
    chk("wr3_we", 32'(bus.rf_write_ctrl), 32'd1);
    chk("wr3_addr", 32'(bus.rf_reg_in), 32'd3);
    chk("wr3_data", 32'(bus.rf_data_in), 32'hA5);
    model[3] = 8'hA5; exp_last = 4'd3;
    tick();
    core_drive(1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge CLK);
    chk("rd3_we", 32'(bus.rf_write_ctrl), 32'd0);
    chk("rd3_data", 32'(bus.core_rdata), 32'(model[3]));
    tick();
    core_drive(1'b0, 1'b1, 4'd9, 8'h77);
    @(negedge CLK);
    chk("idle_we", 32'(bus.rf_write_ctrl), 32'd0);
    chk("idle_hold", 32'(bus.rf_reg_in), 32'(exp_last));
    tick();

`ifdef REGF_DBG_EN
    // Both requesting: debug wins once every STARVE+1 cycles.
    core_drive(1'b1, 1'b0, 4'd1, 8'h00);
    dbg_drive(1'b1, 1'b0, 4'd3, 1'b0);
    prev_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_d = ((k % (STARVE + 1)) == STARVE);
      @(negedge CLK);
      chk("starve_cgnt", 32'(bus.core_gnt), 32'(!exp_d));
      chk("starve_dgnt", 32'(bus.dbg_gnt), 32'(exp_d));
      chk("starve_rvalid", 32'(bus.dbg_rvalid), 32'(prev_d));
      if (prev_d) chk("starve_rdata", 32'(bus.dbg_rdata), 32'(model[3]));
      prev_d = exp_d;
      exp_last = exp_d ? 4'd3 : 4'd1;
      tick();
    end
    dbg_drive(1'b0, 1'b0, 4'd0, 1'b0);
    core_drive(1'b1, 1'b1, 4'd15, 8'h3C);
    @(negedge CLK);
    chk("pre15_gnt", 32'(bus.core_gnt), 32'd1);
    model[15] = 8'h3C;
    tick();

    // Halt: core locked out from the next cycle, debug reads addr 15.
    core_drive(1'b1, 1'b0, 4'd1, 8'h00);
    dbg_drive(1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge CLK);
    chk("halt0_cgnt", 32'(bus.core_gnt), 32'd1);
    tick();
    @(negedge CLK);
    chk("halt1_cgnt", 32'(bus.core_gnt), 32'd0);
    tick();
    dbg_drive(1'b1, 1'b0, 4'd15, 1'b1);
    @(negedge CLK);
    chk("halt_dgnt", 32'(bus.dbg_gnt), 32'd1);
    chk("halt_cgnt", 32'(bus.core_gnt), 32'd0);
    tick();
    dbg_drive(1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge CLK);
    chk("halt_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    chk("halt_rdata", 32'(bus.dbg_rdata), 32'(model[15]));
    chk("unhalt_cgnt", 32'(bus.core_gnt), 32'd0);
    tick();
    @(negedge CLK);
    chk("run_cgnt", 32'(bus.core_gnt), 32'd1);
    exp_last = 4'd1;
    exp_dbg_rdata = model[15];
    tick();
`endif

    // Random core traffic; debug inputs are noise the default build must ignore.
    for (int n = 0; n < 80; n++) begin
      c_req  = ($urandom_range(0, 3) != 0);
      c_we   = 1'($urandom_range(0, 1));
      c_addr = 4'($urandom_range(0, 15));
      c_wd   = 8'($urandom);
      d_req  = 1'($urandom_range(0, 1));
      d_halt = 1'($urandom_range(0, 1));
`ifdef REGF_DBG_EN
      d_req = 1'b0; d_halt = 1'b0;
`endif
      core_drive(c_req, c_we, c_addr, c_wd);
      dbg_drive(d_req, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d_halt);
      @(negedge CLK);
      chk("rnd_cgnt", 32'(bus.core_gnt), 32'(c_req));
      chk("rnd_we", 32'(bus.rf_write_ctrl), 32'(c_req && c_we));
      chk("rnd_dgnt", 32'(bus.dbg_gnt), 32'd0);
      chk("rnd_rvalid", 32'(bus.dbg_rvalid), 32'd0);
      chk("rnd_drdata", 32'(bus.dbg_rdata), 32'(exp_dbg_rdata));
      chk("rnd_addr", 32'(bus.rf_reg_in), 32'(c_req ? c_addr : exp_last));
      if (c_req && c_we) chk("rnd_wdata", 32'(bus.rf_data_in), 32'(c_wd));
      if (c_req && !c_we) chk("rnd_rdata", 32'(bus.core_rdata), 32'(model[c_addr]));
      if (c_req) begin
        exp_last = c_addr;
        if (c_we) model[c_addr] = c_wd;
      end
      tick();
    end

    // Reset in the middle of a granted write: write dropped, sweep restarts.
    dbg_drive(1'b0, 1'b0, 4'd0, 1'b0);
    core_drive(1'b1, 1'b1, 4'd7, 8'h55);
    tick();
    RESET = 1'b1;
    core_drive(1'b1, 1'b1, 4'd7, 8'hFF);
    @(negedge CLK);
    chk("rstw_we", 32'(bus.rf_write_ctrl), 32'd0);
    chk("rstw_cgnt", 32'(bus.core_gnt), 32'd0);
    chk("rstw_busy", 32'(bus.busy), 32'd1);
    tick();
    RESET = 1'b0;
    core_drive(1'b0, 1'b0, 4'd0, 8'h00);
    sweep_check("resweep");
    core_drive(1'b1, 1'b0, 4'd7, 8'h00);
    @(negedge CLK);
    chk("rd7_gnt", 32'(bus.core_gnt), 32'd1);
    chk("rd7_data", 32'(bus.core_rdata), 32'(model[7]));
    chk("rd7_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
